// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// A saturating watchdog aborts cycles that never see an ack.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W:0]   TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cyc_d, we_d, rsp_valid_d, rsp_err_d;
    logic               cmd_ready_d, busy_d;
    logic [SEL_W-1:0]   sel_d;
    logic [DAT_W-1:0]   adr_d, dat_d, rsp_dat_d;
    logic               cnt_hit;

    // The cycle about to finish would be the TIMEOUT_CYCLES-th stb cycle without ack
    assign cnt_hit = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= TIMEOUT_LIM;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = BUS;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_we ? cmd_dat : '0;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_hit) begin
                        state_d     = RESP;
                        cyc_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = TIMEOUT_DATA;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            wbm_cyc_o <= cyc_d;
            wbm_stb_o <= cyc_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: driver queues expectations, a responder model acks,
// and a monitor compares every response.
module tb_wb_initiator;

    localparam int unsigned TO    = 8;
    localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int unsigned delay;
    } bus_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int unsigned lat;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int unsigned cyc_n  = 0;
    int          ready_mode = 0;

    wb_initiator #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TDATA)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc_n);
    endtask

    // Reference: an ack in stb cycle delay+1 wins unless that exceeds the timeout
    task automatic start_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [31:0] rdata,
                             input int unsigned delay);
        bus_t b;
        rsp_t r;
        logic acked;
        b = '{we: we, sel: sel, adr: adr, dat: dat, rdata: rdata, delay: delay};
        acked = (delay + 1 <= TO);
        r.err = !acked;
        r.dat = !acked ? TDATA : (we ? 32'h0 : rdata);
        r.lat = (acked ? delay + 1 : TO) + 1;
        bus_q.push_back(b);
        exp_q.push_back(r);
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(input logic keep);
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check_eq("accept_timeout", 32'(cmd_ready), 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'h0);
    endtask

    // Response consumer
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Wishbone responder model; acks when idle are noise the initiator must ignore
    initial begin
        bus_t        cur;
        logic        active;
        int unsigned n;
        int unsigned exp_n;
        active    = 1'b0;
        n         = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        cur = '{we: 1'b0, sel: 4'h0, adr: 32'h0, dat: 32'h0, rdata: 32'h0, delay: 0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active    = 1'b0;
                wbm_ack_i = 1'b0;
            end else if (wbm_cyc_o) begin
                if (!active) begin
                    if (bus_q.size() == 0) check_eq("cycle_without_cmd", 32'(wbm_cyc_o), 32'h0);
                    else cur = bus_q.pop_front();
                    active = 1'b1;
                    n      = 0;
                end
                n++;
                check_eq("stb_with_cyc", 32'(wbm_stb_o), 32'h1);
                check_eq("bus_we", 32'(wbm_we_o), 32'(cur.we));
                check_eq("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
                check_eq("bus_adr", wbm_adr_o, cur.adr);
                check_eq("bus_dat", wbm_dat_o, cur.we ? cur.dat : 32'h0);
                wbm_ack_i = (n == cur.delay + 1);
                wbm_dat_i = wbm_ack_i ? cur.rdata : $urandom;
            end else begin
                if (active) begin
                    exp_n = (cur.delay + 1 < TO) ? cur.delay + 1 : TO;
                    check_eq("stb_cycles", 32'(n), 32'(exp_n));
                    active = 1'b0;
                end
                check_eq("stb_without_cyc", 32'(wbm_stb_o), 32'h0);
                wbm_ack_i = ($urandom_range(0, 2) == 0);
                wbm_dat_i = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake
    initial begin
        int unsigned acc_cyc;
        logic        prev_v;
        rsp_t        e;
        acc_cyc = 0;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) acc_cyc = cyc_n;
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_rsp", 32'(rsp_valid), 32'h0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_v) check_eq("rsp_latency", 32'(cyc_n - acc_cyc), 32'(e.lat));
                        check_eq("rsp_dat", rsp_dat, e.dat);
                        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                        check_eq("cmd_ready_in_resp", 32'(cmd_ready), 32'h0);
                        check_eq("cyc_in_resp", 32'(wbm_cyc_o), 32'h0);
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
                prev_v = rsp_valid && !rsp_ready;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int unsigned n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_sel   = '0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        check_eq("rst_stb", 32'(wbm_stb_o), 32'h0);
        check_eq("rst_rsp_dat", rsp_dat, 32'h0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
        check_eq("rst_adr", wbm_adr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write acked after 3 wait cycles, read acked in first cycle, timeout, ack on timeout
        start_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234, 32'h0, 3);
        wait_accept(1'b0);
        wait_idle();
        start_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h1111_2222, 32'h0000_00FF, 0);
        wait_accept(1'b0);
        wait_idle();
        start_cmd(1'b0, 4'h3, 32'h3000_0008, 32'h0, 32'h5555_AAAA, 20);
        wait_accept(1'b0);
        wait_idle();
        start_cmd(1'b0, 4'hC, 32'h3000_000C, 32'h0, 32'h1234_5678, TO - 1);
        wait_accept(1'b0);
        wait_idle();

        // Backpressure with the next command held valid
        ready_mode = 1;
        @(posedge clk);
        #1;
        start_cmd(1'b0, 4'hF, 32'h3000_0010, 32'h0, 32'hCAFE_0001, 1);
        wait_accept(1'b1);
        start_cmd(1'b1, 4'h5, 32'h3000_0014, 32'h0BAD_F00D, 32'h0, 2);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            check_eq("bp_no_cyc", 32'(wbm_cyc_o), 32'h0);
            check_eq("bp_rsp_hold", 32'(rsp_valid), 32'h1);
        end
        ready_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 50);
        @(negedge clk);
        check_eq("accept_after_hs", 32'(cmd_ready && cmd_valid), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a bus cycle
        start_cmd(1'b0, 4'hF, 32'h3000_0020, 32'h0, 32'h7777_7777, 30);
        wait_accept(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_stb", 32'(wbm_stb_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cyc", 32'(wbm_cyc_o), 32'h0);
        check_eq("mid_rst_stb", 32'(wbm_stb_o), 32'h0);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        exp_q.delete();
        bus_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check_eq("post_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        start_cmd(1'b0, 4'hF, 32'h3000_0024, 32'h0, 32'h2468_ACE0, 2);
        wait_accept(1'b0);
        wait_idle();

        // Randomized traffic with random consumer backpressure
        ready_mode = 2;
        repeat (40) begin
            start_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
                      $urandom_range(0, 10));
            wait_accept(1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        ready_mode = 0;
        repeat (4) @(posedge clk);
        check_eq("bus_q_empty", 32'(bus_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
